// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared types and constants for the 1-to-2 stream demux.
// Routing state encoding and output port indices.
package stream_demux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } demux_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/stream_out_slot.sv
// stream_out_slot: one-entry output register slice with beat counter.
// A load always wins over a drain so the slot sustains one beat per cycle.
module stream_out_slot #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic [CNT_W-1:0]  cnt_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fire;

    assign fire = valid_q && ready_i;

    // Next slot contents: load takes priority, otherwise a drain empties it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (fire) begin
            valid_d = 1'b0;
        end
    end

    // Slot and counter registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/stream_demux2.sv
// stream_demux2: registered 1-to-2 stream demux, select locked per packet.
// The packet's first beat picks the port; later beats follow it until last.
module stream_demux2
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sel,
    input  logic              s_last,
    output logic              m0_valid,
    input  logic              m0_ready,
    output logic [DATA_W-1:0] m0_data,
    output logic              m0_last,
    output logic              m1_valid,
    input  logic              m1_ready,
    output logic [DATA_W-1:0] m1_data,
    output logic              m1_last,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    demux_state_t state_q, state_d;
    logic         lock_sel_q, lock_sel_d;
    logic         esel;
    logic         room0, room1;
    logic         accept;
    logic         load0, load1;

    // Effective select: live input at a packet start, stored one mid-packet.
    always_comb begin
        esel = (state_q == LOCKED) ? lock_sel_q : s_sel;
    end

    assign room0 = !m0_valid || m0_ready;
    assign room1 = !m1_valid || m1_ready;

    // Only the selected slot's room matters, giving head-of-line blocking.
    always_comb begin
        s_ready = (esel == PORT1) ? room1 : room0;
    end

    assign accept = s_valid && s_ready;
    assign load0  = accept && (esel == PORT0);
    assign load1  = accept && (esel == PORT1);

    // Packet tracking: lock on a non-final start beat, release on last.
    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        unique case (state_q)
            IDLE: begin
                if (accept && !s_last) begin
                    state_d    = LOCKED;
                    lock_sel_d = s_sel;
                end
            end
            LOCKED: begin
                if (accept && s_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Routing state and locked select registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_sel_q <= PORT0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
        end
    end

    stream_out_slot #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slot0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load0),
        .data_i  (s_data),
        .last_i  (s_last),
        .ready_i (m0_ready),
        .valid_o (m0_valid),
        .data_o  (m0_data),
        .last_o  (m0_last),
        .cnt_o   (cnt0)
    );

    stream_out_slot #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load1),
        .data_i  (s_data),
        .last_i  (s_last),
        .ready_i (m1_ready),
        .valid_o (m1_valid),
        .data_o  (m1_data),
        .last_o  (m1_last),
        .cnt_o   (cnt1)
    );

endmodule

// File: tb/tb_stream_demux2.sv
// tb_stream_demux2: directed stimulus, packet-level reference model.
// The narrow counter width exercises wraparound within a short run.
module tb_stream_demux2;

    localparam int DATA_W  = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_sel;
    logic              s_last;
    logic              m0_valid, m1_valid;
    logic              m0_ready, m1_ready;
    logic [DATA_W-1:0] m0_data, m1_data;
    logic              m0_last, m1_last;
    logic [CNT_W-1:0]  cnt0, cnt1;

    int checks   = 0;
    int failures = 0;
    int stalls   = 0;

    logic [8:0] rx0[$];
    logic [8:0] rx1[$];

    // Reference model: what each port's consumer must currently see.
    bit         armed = 1'b0;
    bit         in_pkt = 1'b0;
    bit         pkt_port = 1'b0;
    bit         mv[2];
    logic [7:0] md[2];
    bit         ml[2];
    int         mc[2];

    always #5 clk = ~clk;

    stream_demux2 #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_sel    (s_sel),
        .s_last   (s_last),
        .m0_valid (m0_valid),
        .m0_ready (m0_ready),
        .m0_data  (m0_data),
        .m0_last  (m0_last),
        .m1_valid (m1_valid),
        .m1_ready (m1_ready),
        .m1_data  (m1_data),
        .m1_last  (m1_last),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit dest();
        return in_pkt ? pkt_port : s_sel;
    endfunction

    function automatic bit cons_ready(input bit p);
        return p ? m1_ready : m0_ready;
    endfunction

    function automatic bit model_ready();
        bit p;
        p = dest();
        return !mv[p] || cons_ready(p);
    endfunction

    // Advance the model on each edge using the inputs present at that edge.
    always @(posedge clk) begin
        bit p, acc, fire;
        if (!rst_n) begin
            armed    <= 1'b1;
            in_pkt   <= 1'b0;
            pkt_port <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mv[i] <= 1'b0;
                md[i] <= '0;
                ml[i] <= 1'b0;
                mc[i] <= 0;
            end
        end else begin
            p   = dest();
            acc = s_valid && model_ready();
            for (int i = 0; i < 2; i++) begin
                fire = mv[i] && cons_ready(i[0]);
                if (fire) mc[i] <= (mc[i] + 1) % CNT_MOD;
                if (acc && (p == i[0])) begin
                    mv[i] <= 1'b1;
                    md[i] <= s_data;
                    ml[i] <= s_last;
                end else if (fire) begin
                    mv[i] <= 1'b0;
                end
            end
            if (acc) begin
                if (!in_pkt && !s_last) begin
                    in_pkt   <= 1'b1;
                    pkt_port <= s_sel;
                end else if (in_pkt && s_last) begin
                    in_pkt <= 1'b0;
                end
            end
        end
    end

    // Record every delivered beat per port for order checks.
    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            if (m0_valid && m0_ready) rx0.push_back({m0_last, m0_data});
            if (m1_valid && m1_ready) rx1.push_back({m1_last, m1_data});
        end
    end

    // Mid-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("s_ready", s_ready, model_ready());
            chk("m0_valid", m0_valid, mv[0]);
            chk("m1_valid", m1_valid, mv[1]);
            if (mv[0]) begin
                chk("m0_data", m0_data, md[0]);
                chk("m0_last", m0_last, ml[0]);
            end
            if (mv[1]) begin
                chk("m1_data", m1_data, md[1]);
                chk("m1_last", m1_last, ml[1]);
            end
            chk("cnt0", cnt0, mc[0]);
            chk("cnt1", cnt1, mc[1]);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        idle(1);
        rst_n = 1'b1;
        rx0.delete();
        rx1.delete();
        stalls = 0;
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit last);
        bit r;
        r       = 1'b0;
        s_valid = 1'b1;
        s_sel   = sel;
        s_data  = d;
        s_last  = last;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            r = s_ready;
            if (!r) stalls++;
            @(posedge clk);
            #2;
            if (r) break;
        end
        if (!r) chk("send_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    task automatic zeros_check(input string tag);
        @(negedge clk);
        chk({tag, "_s_ready"}, s_ready, 1);
        chk({tag, "_outs"}, {m0_valid, m1_valid, m0_last, m1_last}, 0);
        chk({tag, "_data"}, {m0_data, m1_data}, 0);
        chk({tag, "_cnts"}, {cnt0, cnt1}, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_sel    = 1'b0;
        s_last   = 1'b0;
        m0_ready = 1'b1;
        m1_ready = 1'b1;
        idle(2);
        zeros_check("rst");
        idle(1);
        rst_n = 1'b1;
        idle(1);

        // Single-beat packet to port 1.
        send(1'b1, 8'hA5, 1'b1);
        @(negedge clk);
        chk("t1_m1_valid", m1_valid, 1);
        chk("t1_m1_data", m1_data, 8'hA5);
        chk("t1_m1_last", m1_last, 1);
        chk("t1_m0_valid", m0_valid, 0);
        idle(1);
        @(negedge clk);
        chk("t1_cnt1", cnt1, 1);
        chk("t1_m1_drained", m1_valid, 0);

        // Packet lock while s_sel toggles.
        do_reset();
        send(1'b0, 8'h10, 1'b0);
        send(1'b1, 8'h11, 1'b0);
        send(1'b0, 8'h12, 1'b0);
        send(1'b1, 8'h13, 1'b1);
        idle(3);
        chk("t2_rx0_len", rx0.size(), 4);
        chk("t2_rx1_len", rx1.size(), 0);
        if (rx0.size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk("t2_rx0_beat", rx0[i], {i == 3, 8'(8'h10 + i)});
        end
        chk("t2_cnt0", cnt0, 4);
        chk("t2_cnt1", cnt1, 0);

        // Backpressure on port 0.
        do_reset();
        m0_ready = 1'b0;
        send(1'b0, 8'h20, 1'b1);
        s_valid = 1'b1;
        s_sel   = 1'b0;
        s_data  = 8'h21;
        s_last  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("t3_s_ready_low", s_ready, 0);
            chk("t3_m0_hold", m0_data, 8'h20);
            chk("t3_m0_valid", m0_valid, 1);
            idle(1);
        end
        m0_ready = 1'b1;
        @(negedge clk);
        chk("t3_s_ready_high", s_ready, 1);
        idle(1);
        s_valid = 1'b0;
        idle(3);
        chk("t3_rx0_len", rx0.size(), 2);
        if (rx0.size() == 2) begin
            chk("t3_rx0_a", rx0[0], 9'h120);
            chk("t3_rx0_b", rx0[1], 9'h121);
        end
        chk("t3_cnt0", cnt0, 2);

        // Streaming alternating single-beat packets.
        do_reset();
        for (int i = 0; i < 16; i++)
            send(i[0], 8'(8'h30 + i), 1'b1);
        chk("t4_stalls", stalls, 0);
        idle(3);
        chk("t4_cnt0", cnt0, 8);
        chk("t4_cnt1", cnt1, 8);
        chk("t4_rx_len", rx0.size() + rx1.size(), 16);
        if (rx0.size() > 0) chk("t4_rx0_first", rx0[0], 9'h130);
        if (rx1.size() > 0) chk("t4_rx1_first", rx1[0], 9'h131);

        // Reset in the middle of a packet on port 1.
        do_reset();
        send(1'b1, 8'h40, 1'b0);
        send(1'b1, 8'h41, 1'b0);
        do_reset();
        zeros_check("t5");
        idle(1);
        send(1'b0, 8'h50, 1'b1);
        idle(3);
        chk("t5_rx0_len", rx0.size(), 1);
        if (rx0.size() == 1) chk("t5_rx0", rx0[0], 9'h150);
        chk("t5_rx1_len", rx1.size(), 0);
        chk("t5_cnt0", cnt0, 1);
        chk("t5_cnt1", cnt1, 0);

        // Counter wrap: 17 beats on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++)
            send(1'b0, 8'(8'h60 + i), 1'b1);
        idle(3);
        chk("t6_cnt0_wrap", cnt0, 1);
        chk("t6_rx0_len", rx0.size(), 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stream_demux2.md
# stream_demux2

Registered 1-to-2 stream demultiplexer with valid/ready handshakes. It routes each beat of a single input stream to one of two output ports, chosen by a select input. Selection is locked for a whole packet, delimited by `s_last`. It is the distribution counterpart of the team's 2:1 select logic and sits wherever one producer feeds two consumers.

## Interface
- `DATA_W`, default 8: payload width in bits.
- `CNT_W`, default 16: width of each per-port beat counter.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset; sampled on the `clk` rising edge.
- `s_valid` input 1: input beat present.
- `s_ready` output 1: input beat accepted this cycle when high together with `s_valid`.
- `s_data` input DATA_W: input payload.
- `s_sel` input 1: destination, 0 = port 0, 1 = port 1; sampled only on the first beat of a packet.
- `s_last` input 1: marks the final beat of a packet.
- `m0_valid`, `m1_valid` output 1: output beat present on port 0 / port 1.
- `m0_ready`, `m1_ready` input 1: consumer on port 0 / port 1 accepts.
- `m0_data`, `m1_data` output DATA_W: registered payload for each port.
- `m0_last`, `m1_last` output 1: registered `s_last` for each port.
- `cnt0`, `cnt1` output CNT_W: beats delivered on port 0 / port 1; wraps modulo 2^CNT_W.

## Operation
- Routing state machine, two states:
  - IDLE: effective select `esel = s_sel`.
  - LOCKED: `esel = lock_sel`.
- IDLE transitions: on accepting a beat with `s_last=0`, store `lock_sel <= s_sel` and go to LOCKED. On accepting a beat with `s_last=1` (single-beat packet), stay in IDLE.
- LOCKED transitions: `s_sel` is ignored. On accepting a beat with `s_last=1`, return to IDLE.
- Each port has a one-entry output slot holding `valid`, `data` and `last`.
- `s_ready = !slotX_valid || mX_ready`, with X = `esel`.
  - `s_ready` is combinational from `s_sel` in IDLE and from `mX_ready`.
  - `s_ready` does not depend on `s_valid`.
- Slot X update when an input beat is accepted: slot X loads `s_data`/`s_last` and sets valid. This holds even if slot X is being drained in the same cycle, giving back-to-back throughput of 1 beat/cycle.
- A slot with `mX_valid && mX_ready` and no new load clears valid.
- Output slot contents are stable while `mX_valid && !mX_ready`.
- The non-selected port drains independently. It is never loaded while the other port is selected.
- Head-of-line blocking is by design: a stalled target port stalls the input even if the other port is free.
- `cntX` increments on every `mX_valid && mX_ready`, wrapping from 2^CNT_W-1 to 0.
- Reset (`rst_n=0` at an edge):
  - State returns to IDLE and `lock_sel` clears to 0.
  - Both slots go invalid and data/last clear to 0; `cnt0` and `cnt1` clear to 0.
  - A packet in flight is abandoned. The next accepted beat is treated as a packet start.

## Timing
- Latency: a beat accepted at edge N appears on `mX_valid`/`mX_data` after edge N, i.e. during cycle N+1.
- Throughput: 1 beat/cycle per stream when the consumer holds `mX_ready=1`.
- Reset values, holding during and after reset until the first accepted beat: `s_ready` equals 1, since both slots are empty; `m0_valid`, `m1_valid`, `m0_last`, `m1_last`, `m0_data`, `m1_data`, `cnt0` and `cnt1` are all 0.
- Consumer drain and producer load of the same slot in one cycle: both take effect, and the counter increments.
- A packet that switches ports relative to the previous one may start in the cycle after the previous `s_last` beat is accepted. There is no bubble.

## Structure
- Package `stream_demux_pkg`:
  - state enum `demux_state_t` {IDLE, LOCKED};
  - port index constants `PORT0 = 1'b0` and `PORT1 = 1'b1`.
- Sub-module `stream_out_slot`, instantiated twice: a one-entry register slice with load, drain, valid/data/last and a beat counter, parameterised by `DATA_W` and `CNT_W`.
- Top level: FSM, `lock_sel` register, `esel` mux, and the `s_ready` mux.

## Test plan
- Reset then a single beat: `s_sel=1`, `s_data=8'hA5`, `s_last=1`, `m1_ready=1`. Required: `m1_valid` with `8'hA5`/last=1 in the next cycle, `m0_valid` stays 0, `cnt1=1`, state IDLE.
- Packet lock: 4-beat packet 8'h10..8'h13 with `s_sel` toggling every beat and first `s_sel=0`. Required: all 4 beats on port 0 in order, last only on 8'h13, `cnt0=4`, `cnt1=0`.
- Backpressure: `m0_ready=0` with a beat in slot 0 and a second beat offered for port 0. Required: `s_ready=0` and `m0_data` held. When `m0_ready` rises, the second beat is accepted in the same cycle and no beat is lost or duplicated.
- Streaming: 16 single-beat packets alternating port 0/1, with both readies held at 1. Required: `s_ready` stays 1 throughout (no bubbles), and `cnt0=cnt1=8`.
- Reset mid-packet: after 2 beats of a 5-beat packet on port 1, assert `rst_n=0` for one edge, then send a 1-beat packet with `s_sel=0`. Required: all outputs and counters read 0 after reset, and the new beat exits port 0.
- Counter wrap with `CNT_W=4`: 17 beats on port 0. Required: `cnt0=1`.
